// File: rtl/cbd_sampler_stream.sv
// Streaming CBD sampler: requests PRF blocks per polynomial, buffers the bit
// stream and emits LANES centred-binomial coefficients per beat (eta 2 or 3).
module cbd_sampler_stream #(
  parameter int NUM_POLY = 6,
  parameter int LANES    = 8,
  parameter int RATE_W   = 1088,
  parameter int Q        = 3329,
  parameter int COEF_W   = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      eta3_i,
  input  logic [7:0]                nonce_base_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      prf_req_valid_o,
  input  logic                      prf_req_ready_i,
  output logic [7:0]                prf_nonce_o,
  input  logic                      prf_blk_valid_i,
  output logic                      prf_blk_ready_o,
  input  logic [RATE_W-1:0]         prf_blk_i,
  output logic                      coef_valid_o,
  input  logic                      coef_ready_i,
  output logic [LANES*COEF_W-1:0]   coef_o,
  output logic [7:0]                coef_idx_o,
  output logic [7:0]                coef_poly_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // REQ   | PRF request for nonce_base + poly_cnt outstanding
  // LOAD  | waiting for a rate block to append to the buffer
  // EMIT  | presenting beats while the buffer holds a full beat
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_LOAD, S_EMIT, S_DONE} state_t;

  localparam int BEAT_MAX = LANES * 6;
  localparam int BUF_W    = RATE_W + BEAT_MAX - 1;
  localparam int CNT_W    = $clog2(BUF_W + 1);

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   beat_bits;
  logic               eta3_q;
  logic [7:0]         nonce_base_q;
  logic [7:0]         poly_cnt_q;
  logic [7:0]         coef_idx_q;
  logic               beat_avail, last_beat, last_poly;
  logic               start_acc, blk_hs, beat_hs;

  assign beat_bits  = eta3_q ? CNT_W'(LANES * 6) : CNT_W'(LANES * 4);
  assign beat_avail = cnt_q >= beat_bits;
  assign last_beat  = coef_idx_q == 8'(256 - LANES);
  assign last_poly  = ({1'b0, poly_cnt_q} + 9'd1) >= 9'(NUM_POLY);

  assign start_acc = (state_q == S_IDLE) && start_i;
  assign blk_hs    = prf_blk_ready_o && prf_blk_valid_i;
  assign beat_hs   = coef_valid_o && coef_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    prf_req_valid_o = 1'b0;
    prf_blk_ready_o = 1'b0;
    coef_valid_o    = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_REQ;
      S_REQ: begin
        busy_o          = 1'b1;
        prf_req_valid_o = 1'b1;
        if (prf_req_ready_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy_o          = 1'b1;
        prf_blk_ready_o = 1'b1;
        if (prf_blk_valid_i) state_d = S_EMIT;
      end
      S_EMIT: begin
        busy_o = 1'b1;
        if (!beat_avail) begin
          state_d = S_LOAD;
        end else begin
          coef_valid_o = 1'b1;
          if (coef_ready_i && last_beat) state_d = last_poly ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bits above cnt_q are kept zero so a new block can simply be OR-ed in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q        <= '0;
      cnt_q        <= '0;
      eta3_q       <= 1'b0;
      nonce_base_q <= '0;
      poly_cnt_q   <= '0;
      coef_idx_q   <= '0;
    end else begin
      if (start_acc) begin
        eta3_q       <= eta3_i;
        nonce_base_q <= nonce_base_i;
        poly_cnt_q   <= '0;
        coef_idx_q   <= '0;
        buf_q        <= '0;
        cnt_q        <= '0;
      end
      if (blk_hs) begin
        buf_q <= buf_q | (BUF_W'(prf_blk_i) << cnt_q);
        cnt_q <= cnt_q + CNT_W'(RATE_W);
      end
      if (beat_hs) begin
        coef_idx_q <= coef_idx_q + 8'(LANES);
        if (last_beat) begin
          buf_q      <= '0;
          cnt_q      <= '0;
          poly_cnt_q <= poly_cnt_q + 8'd1;
        end else begin
          buf_q <= buf_q >> beat_bits;
          cnt_q <= cnt_q - beat_bits;
        end
      end
    end
  end

  assign prf_nonce_o = nonce_base_q + poly_cnt_q;
  assign coef_idx_o  = coef_idx_q;
  assign coef_poly_o = poly_cnt_q;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [5:0] grp;
    logic [1:0] pa, pb;
    assign grp = eta3_q ? buf_q[j*6 +: 6] : {2'b00, buf_q[j*4 +: 4]};
    assign pa  = eta3_q ? 2'(grp[0]) + 2'(grp[1]) + 2'(grp[2])
                        : 2'(grp[0]) + 2'(grp[1]);
    assign pb  = eta3_q ? 2'(grp[3]) + 2'(grp[4]) + 2'(grp[5])
                        : 2'(grp[2]) + 2'(grp[3]);
    assign coef_o[j*COEF_W +: COEF_W] = (pa >= pb) ? COEF_W'(pa - pb)
                                      : COEF_W'(Q) + COEF_W'(pa) - COEF_W'(pb);
  end

endmodule

// File: tb/tb_cbd_sampler_stream.sv
// Bench for cbd_sampler_stream: PRF/consumer models with a beat scoreboard
// filled from a software CBD model at each request handshake.
module tb_cbd_sampler_stream;
  localparam int NUM_POLY = 6;
  localparam int LANES    = 8;
  localparam int RATE_W   = 1088;
  localparam int Q        = 3329;
  localparam int COEF_W   = 12;

  logic clk_i = 1'b0;
  logic rst_i, start_i, eta3_i;
  logic [7:0] nonce_base_i;
  logic busy_o, done_o, prf_req_valid_o, prf_req_ready_i;
  logic [7:0] prf_nonce_o;
  logic prf_blk_valid_i, prf_blk_ready_o;
  logic [RATE_W-1:0] prf_blk_i;
  logic coef_valid_o, coef_ready_i;
  logic [LANES*COEF_W-1:0] coef_o;
  logic [7:0] coef_idx_o, coef_poly_o;

  cbd_sampler_stream #(.NUM_POLY(NUM_POLY), .LANES(LANES), .RATE_W(RATE_W),
                       .Q(Q), .COEF_W(COEF_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .eta3_i(eta3_i),
    .nonce_base_i(nonce_base_i), .busy_o(busy_o), .done_o(done_o),
    .prf_req_valid_o(prf_req_valid_o), .prf_req_ready_i(prf_req_ready_i),
    .prf_nonce_o(prf_nonce_o), .prf_blk_valid_i(prf_blk_valid_i),
    .prf_blk_ready_o(prf_blk_ready_o), .prf_blk_i(prf_blk_i),
    .coef_valid_o(coef_valid_o), .coef_ready_i(coef_ready_i), .coef_o(coef_o),
    .coef_idx_o(coef_idx_o), .coef_poly_o(coef_poly_o));

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]              poly;
    logic [7:0]              idx;
    logic [LANES*COEF_W-1:0] data;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;

  int cfg_mode = 0, rdy_pct = 100, dly_max = 0;
  bit cfg_e3 = 0;
  logic [7:0] cfg_base = '0;
  bit have_req = 0, req_fire_q = 0, blk_fire_q = 0, hold_q = 0;
  int blk_no = 0, wait_cnt = 0, exp_poly = 0, beats = 0, blk_hs = 0, done_cnt = 0;
  logic [RATE_W-1:0] cur_b0, cur_b1;
  logic [LANES*COEF_W-1:0] h_data, first_data;
  logic [7:0] h_idx, h_poly;

  function automatic logic [RATE_W-1:0] gen_blk(input int mode, input int bn);
    logic [RATE_W-1:0] r;
    for (int k = 0; k < RATE_W; k++) begin
      case (mode)
        0: r[k] = 1'b0;
        1: r[k] = (k % 8) < 2;
        2: r[k] = ((k % 8) == 2) || ((k % 8) == 3);
        3: r[k] = 1'b1;
        4: r[k] = ((bn * RATE_W + k) % 6) >= 3;
        default: r[k] = 1'($urandom_range(1));
      endcase
    end
    return r;
  endfunction

  task automatic push_poly(input logic [7:0] p, input bit e3,
                           input logic [RATE_W-1:0] b0, input logic [RATE_W-1:0] b1);
    logic [2*RATE_W-1:0] s;
    int eta, a, b, v, i;
    beat_t e;
    s = {b1, b0};
    eta = e3 ? 3 : 2;
    for (int k = 0; k < 256 / LANES; k++) begin
      e.poly = p;
      e.idx  = 8'(k * LANES);
      e.data = '0;
      for (int j = 0; j < LANES; j++) begin
        i = k * LANES + j;
        a = 0;
        b = 0;
        for (int t = 0; t < eta; t++) begin
          a += int'(s[2*eta*i + t]);
          b += int'(s[2*eta*i + eta + t]);
        end
        v = (a >= b) ? a - b : Q + a - b;
        e.data[j*COEF_W +: COEF_W] = COEF_W'(v);
      end
      sb.push_back(e);
    end
  endtask

  // PRF and consumer models, acting 1 time unit after each falling edge.
  initial begin
    forever begin
      @(negedge clk_i);
      #1;
      if (rst_i) begin
        prf_req_ready_i = 0;
        prf_blk_valid_i = 0;
        coef_ready_i    = 0;
        have_req = 0; req_fire_q = 0; blk_fire_q = 0; hold_q = 0;
        exp_poly = 0;
        sb.delete();
      end else begin
        if (done_o) done_cnt++;
        if (blk_fire_q) begin
          checks++;
          if (coef_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL blk_to_valid_latency: coef_valid_o=%b expected 1", coef_valid_o);
          end
          blk_no++;
          prf_blk_valid_i = 0;
          wait_cnt = $urandom_range(dly_max);
        end
        if (req_fire_q) begin
          have_req = 1;
          blk_no = 0;
          prf_blk_valid_i = 0;
          wait_cnt = $urandom_range(dly_max);
        end
        if (hold_q) begin
          checks++;
          if (coef_valid_o !== 1'b1 || coef_o !== h_data || coef_idx_o !== h_idx ||
              coef_poly_o !== h_poly) begin
            errors++;
            $display("FAIL stall_stable: valid=%b idx=%0d poly=%0d expected held idx=%0d poly=%0d",
                     coef_valid_o, coef_idx_o, coef_poly_o, h_idx, h_poly);
          end
        end
        prf_req_ready_i = prf_req_valid_o && (dly_max == 0 || $urandom_range(1) == 1);
        if (prf_req_valid_o) begin
          prf_blk_valid_i = 0;
        end else if (have_req && !prf_blk_valid_i) begin
          if (wait_cnt > 0) wait_cnt--;
          else begin
            prf_blk_valid_i = 1;
            prf_blk_i = (blk_no == 0) ? cur_b0 : (blk_no == 1) ? cur_b1 : '1;
          end
        end
        coef_ready_i = $urandom_range(99) < rdy_pct;
        req_fire_q = prf_req_valid_o && prf_req_ready_i;
        blk_fire_q = prf_blk_valid_i && prf_blk_ready_o;
        if (blk_fire_q) blk_hs++;
        if (req_fire_q) begin
          checks++;
          if (prf_nonce_o !== 8'(cfg_base + 8'(exp_poly))) begin
            errors++;
            $display("FAIL req_nonce: got %h expected %h", prf_nonce_o, 8'(cfg_base + 8'(exp_poly)));
          end
          cur_b0 = gen_blk(cfg_mode, 0);
          cur_b1 = gen_blk(cfg_mode, 1);
          push_poly(8'(exp_poly), cfg_e3, cur_b0, cur_b1);
          exp_poly++;
        end
        if (coef_valid_o && coef_ready_i) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: poly=%0d idx=%0d with empty scoreboard", coef_poly_o, coef_idx_o);
          end else begin
            beat_t e;
            e = sb.pop_front();
            if (coef_o !== e.data || coef_idx_o !== e.idx || coef_poly_o !== e.poly) begin
              errors++;
              $display("FAIL beat: got poly=%0d idx=%0d data=%h expected poly=%0d idx=%0d data=%h",
                       coef_poly_o, coef_idx_o, coef_o, e.poly, e.idx, e.data);
            end
          end
          beats++;
          if (beats == 1) first_data = coef_o;
        end
        hold_q = coef_valid_o && !coef_ready_i;
        h_data = coef_o;
        h_idx  = coef_idx_o;
        h_poly = coef_poly_o;
      end
    end
  end

  task automatic run_job(input string name, input bit e3, input logic [7:0] base,
                         input int mode, input int rdy, input int dly,
                         input int l0, input int l1, input int abort_poly);
    bit aborted;
    int c;
    @(negedge clk_i);
    cfg_mode = mode; cfg_e3 = e3; cfg_base = base; rdy_pct = rdy; dly_max = dly;
    beats = 0; blk_hs = 0; done_cnt = 0; exp_poly = 0;
    start_i = 1; eta3_i = e3; nonce_base_i = base;
    aborted = 0;
    c = 0;
    while (c < 4000 && done_cnt == 0 && !aborted) begin
      @(negedge clk_i);
      start_i = (c == 50);
      if (c == 50) begin
        eta3_i = !e3;
        nonce_base_i = 8'h55;
      end
      if (abort_poly >= 0 && coef_valid_o && coef_poly_o == 8'(abort_poly)) begin
        rst_i = 1;
        start_i = 0;
        @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, coef_valid_o, prf_req_valid_o, prf_blk_ready_o, prf_nonce_o,
             coef_o, coef_idx_o, coef_poly_o} !== '0 || done_cnt != 0) begin
          errors++;
          $display("FAIL %s_reset_outputs: busy=%b done=%b valid=%b req=%b idx=%0d poly=%0d done_cnt=%0d expected all 0",
                   name, busy_o, done_o, coef_valid_o, prf_req_valid_o, coef_idx_o, coef_poly_o, done_cnt);
        end
        rst_i = 0;
        aborted = 1;
      end
      c++;
    end
    start_i = 0;
    if (aborted) return;
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: no done_o after %0d cycles", name, c);
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt);
    end
    checks++;
    if (beats != 32 * NUM_POLY) begin
      errors++;
      $display("FAIL %s_beats: got %0d expected %0d", name, beats, 32 * NUM_POLY);
    end
    checks++;
    if (blk_hs != NUM_POLY * (e3 ? 2 : 1)) begin
      errors++;
      $display("FAIL %s_blocks: got %0d expected %0d", name, blk_hs, NUM_POLY * (e3 ? 2 : 1));
    end
    checks++;
    if (sb.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_end_state: left=%0d busy=%b expected 0 and 0", name, sb.size(), busy_o);
    end
    if (l0 >= 0) begin
      checks++;
      if (first_data[0 +: COEF_W] !== COEF_W'(l0) || first_data[COEF_W +: COEF_W] !== COEF_W'(l1)) begin
        errors++;
        $display("FAIL %s_first_lanes: got %0d,%0d expected %0d,%0d", name,
                 first_data[0 +: COEF_W], first_data[COEF_W +: COEF_W], l0, l1);
      end
    end
  endtask

  task automatic test_reset;
    rst_i = 1; start_i = 1; eta3_i = 0; nonce_base_i = 8'h00;
    prf_req_ready_i = 0; prf_blk_valid_i = 0; prf_blk_i = '0; coef_ready_i = 0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({busy_o, done_o, coef_valid_o, prf_req_valid_o, prf_blk_ready_o, prf_nonce_o,
         coef_o, coef_idx_o, coef_poly_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b valid=%b req=%b nonce=%h expected all 0",
               busy_o, coef_valid_o, prf_req_valid_o, prf_nonce_o);
    end
    start_i = 0;
    rst_i = 0;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins_over_start: busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_patterns;
    run_job("eta2_zero", 0, 8'h10, 0, 100, 0, 0, 0, -1);
    run_job("eta2_x03",  0, 8'h20, 1, 100, 0, 2, 0, -1);
    run_job("eta2_x0c",  0, 8'h30, 2, 100, 0, Q - 2, 0, -1);
    run_job("eta2_xff",  0, 8'h40, 3, 100, 0, 0, 0, -1);
    run_job("eta3_grp",  1, 8'h50, 4, 100, 0, Q - 3, Q - 3, -1);
  endtask

  task automatic test_nonce_wrap;
    run_job("nonce_wrap", 0, 8'hFE, 5, 100, 0, -1, -1, -1);
  endtask

  task automatic test_backpressure;
    run_job("stall_eta2", 0, 8'h07, 5, 50, 4, -1, -1, -1);
    run_job("stall_eta3", 1, 8'hF9, 5, 50, 4, -1, -1, -1);
  endtask

  task automatic test_reset_mid;
    run_job("abort", 1, 8'h33, 5, 50, 2, -1, -1, 2);
    run_job("restart", 1, 8'h33, 5, 50, 2, -1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_nonce_wrap();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
